// File: rtl/vc_buffer_if.sv
// Handshake/status bundle between a router input port and its vc_buffer.
// Defining VC_BUF_ALMOST_FULL_EN adds the AFULL status vector.
interface vc_buffer_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
);
    logic                         WR_EN;
    logic [VC_W-1:0]              WR_VC;
    logic [WIDTH-1:0]             WR_DATA;
    logic                         RD_EN;
    logic [VC_W-1:0]              RD_VC;
    logic [WIDTH-1:0]             RD_DATA;
    logic                         RD_VALID;
    logic [NUM_VC-1:0]            FULL;
    logic [NUM_VC-1:0]            EMPTY;
    logic [NUM_VC*(ADDR_W+1)-1:0] COUNT;
    logic                         WR_ERR;
    logic                         RD_ERR;
`ifdef VC_BUF_ALMOST_FULL_EN
    logic [NUM_VC-1:0]            AFULL;
`endif

    modport master (
        output WR_EN, WR_VC, WR_DATA, RD_EN, RD_VC,
        input  RD_DATA, RD_VALID, FULL, EMPTY, COUNT, WR_ERR, RD_ERR
`ifdef VC_BUF_ALMOST_FULL_EN
        , input AFULL
`endif
    );

    modport slave (
        input  WR_EN, WR_VC, WR_DATA, RD_EN, RD_VC,
        output RD_DATA, RD_VALID, FULL, EMPTY, COUNT, WR_ERR, RD_ERR
`ifdef VC_BUF_ALMOST_FULL_EN
        , output AFULL
`endif
    );
endinterface

// File: rtl/vc_buffer.sv
// Multi-VC synchronous FIFO: NUM_VC queues share one storage array, read data registered.
// Define VC_BUF_ALMOST_FULL_EN to add AFULL_THR and the per-VC AFULL output.
module vc_buffer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
`ifdef VC_BUF_ALMOST_FULL_EN
    ,
    parameter int unsigned AFULL_THR = DEPTH - 2
`endif
) (
    input logic        CLK,
    input logic        RSTn,
    vc_buffer_if.slave bus
);
    localparam int unsigned PW = ADDR_W + 1;
    localparam int unsigned MW = NUM_VC * DEPTH;

    logic [PW-1:0]        wptr_q [NUM_VC];
    logic [PW-1:0]        rptr_q [NUM_VC];
    logic [WIDTH-1:0]     mem_q  [MW];
    logic [NUM_VC-1:0]    full;
    logic [NUM_VC-1:0]    empty;
    logic [NUM_VC*PW-1:0] count;

    logic [PW-1:0]          wptr_sel, rptr_sel;
    logic                   full_sel, empty_sel;
    logic                   wr_vc_ok, rd_vc_ok;
    logic                   wr_ok, rd_ok;
    logic [VC_W+ADDR_W-1:0] waddr, raddr;

    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q, wr_err_q, rd_err_q;

    always_comb begin
        full  = '0;
        empty = '0;
        count = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = (wptr_q[v] == rptr_q[v]);
            full[v]  = (wptr_q[v][ADDR_W] != rptr_q[v][ADDR_W]) &&
                       (wptr_q[v][ADDR_W-1:0] == rptr_q[v][ADDR_W-1:0]);
            count[v*PW +: PW] = wptr_q[v] - rptr_q[v];
        end
    end

    // A VC select with no matching channel leaves *_vc_ok low, so it is rejected.
    always_comb begin
        wptr_sel  = '0;
        rptr_sel  = '0;
        full_sel  = 1'b0;
        empty_sel = 1'b1;
        wr_vc_ok  = 1'b0;
        rd_vc_ok  = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.WR_VC == VC_W'(v)) begin
                wptr_sel = wptr_q[v];
                full_sel = full[v];
                wr_vc_ok = 1'b1;
            end
            if (bus.RD_VC == VC_W'(v)) begin
                rptr_sel  = rptr_q[v];
                empty_sel = empty[v];
                rd_vc_ok  = 1'b1;
            end
        end
    end

    assign wr_ok = bus.WR_EN && wr_vc_ok && !full_sel;
    assign rd_ok = bus.RD_EN && rd_vc_ok && !empty_sel;
    assign waddr = {bus.WR_VC, wptr_sel[ADDR_W-1:0]};
    assign raddr = {bus.RD_VC, rptr_sel[ADDR_W-1:0]};

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[waddr] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_ok && bus.WR_VC == VC_W'(v)) begin
                    wptr_q[v] <= wptr_q[v] + PW'(1);
                end
                if (rd_ok && bus.RD_VC == VC_W'(v)) begin
                    rptr_q[v] <= rptr_q[v] + PW'(1);
                end
            end
            if (rd_ok) begin
                rd_data_q <= mem_q[raddr];
            end
            rd_valid_q <= rd_ok;
            wr_err_q   <= bus.WR_EN && !wr_ok;
            rd_err_q   <= bus.RD_EN && !rd_ok;
        end
    end

    assign bus.RD_DATA  = rd_data_q;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.WR_ERR   = wr_err_q;
    assign bus.RD_ERR   = rd_err_q;
    assign bus.FULL     = full;
    assign bus.EMPTY    = empty;
    assign bus.COUNT    = count;

`ifdef VC_BUF_ALMOST_FULL_EN
    logic [NUM_VC-1:0] afull;

    always_comb begin
        afull = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            afull[v] = (32'(count[v*PW +: PW]) >= AFULL_THR);
        end
    end

    assign bus.AFULL = afull;
`endif
endmodule

// File: tb/tb_vc_buffer.sv
// Scoreboard bench for vc_buffer: the driver queues hand-computed per-cycle read/error
// expectations and a negedge monitor pops and compares them.
module tb_vc_buffer;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned NV = 4;
    localparam int unsigned PW = 5;

    typedef struct {
        bit         valid;
        bit         rerr;
        bit         werr;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vc_buffer_if #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) bus ();

    vc_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(bit v, logic [7:0] d, bit re, bit we, bit c);
        exp_t e;
        e.valid = v;
        e.data  = d;
        e.rerr  = re;
        e.werr  = we;
        e.chk   = c;
        return e;
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", int'(bus.RD_VALID), int'(e.valid));
            chk("rd_err", int'(bus.RD_ERR), int'(e.rerr));
            chk("wr_err", int'(bus.WR_ERR), int'(e.werr));
            if (e.valid || e.chk) chk("rd_data", int'(bus.RD_DATA), int'(e.data));
        end
    end

    task automatic drive(bit we, int wvc, logic [7:0] wd, bit re, int rvc, exp_t e);
        bus.WR_EN   = we;
        bus.WR_VC   = 2'(wvc);
        bus.WR_DATA = wd;
        bus.RD_EN   = re;
        bus.RD_VC   = 2'(rvc);
        @(posedge CLK);
        exp_q.push_back(e);
        #1;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
    endtask

    task automatic wr(int vc, logic [7:0] d);
        drive(1'b1, vc, d, 1'b0, 0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic rd(int vc, logic [7:0] d);
        drive(1'b0, 0, 8'h00, 1'b1, vc, mk(1'b1, d, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic st(string nm, int vc, int cnt, bit f, bit e);
        chk({nm, " count"}, int'(bus.COUNT[vc*PW +: PW]), cnt);
        chk({nm, " full"}, int'(bus.FULL[vc]), int'(f));
        chk({nm, " empty"}, int'(bus.EMPTY[vc]), int'(e));
    endtask

    initial begin
        bus.WR_EN   = 1'b0;
        bus.WR_VC   = '0;
        bus.WR_DATA = '0;
        bus.RD_EN   = 1'b0;
        bus.RD_VC   = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst rd_valid", int'(bus.RD_VALID), 0);
        chk("rst rd_data", int'(bus.RD_DATA), 0);
        chk("rst empty", int'(bus.EMPTY), 'hF);
        chk("rst full", int'(bus.FULL), 0);
        chk("rst count", int'(bus.COUNT), 0);
        chk("rst errs", int'({bus.WR_ERR, bus.RD_ERR}), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // Basic order on VC1
        wr(1, 8'h11);
        wr(1, 8'h22);
        wr(1, 8'h33);
        st("vc1 after 3 wr", 1, 3, 1'b0, 1'b0);
        rd(1, 8'h11);
        rd(1, 8'h22);
        rd(1, 8'h33);
        st("vc1 drained", 1, 0, 1'b0, 1'b1);

        // Fill VC2, overflow attempt, drain
        for (int i = 0; i < 16; i++) wr(2, 8'(i));
        st("vc2 full", 2, 16, 1'b1, 1'b0);
        drive(1'b1, 2, 8'hFF, 1'b0, 0, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        st("vc2 overflow", 2, 16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) rd(2, 8'(i));
        st("vc2 drained", 2, 0, 1'b0, 1'b1);

        // Empty read: RD_DATA keeps last popped word
        drive(1'b0, 0, 8'h00, 1'b1, 0, mk(1'b0, 8'h0F, 1'b1, 1'b0, 1'b1));

        // Interleaved VC0/VC3
        for (int i = 0; i < 4; i++) begin
            wr(0, 8'(8'hA0 + i));
            wr(3, 8'(8'hB0 + i));
        end
        st("vc0 interleave", 0, 4, 1'b0, 1'b0);
        st("vc3 interleave", 3, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(0, 8'(8'hA0 + i));
            rd(3, 8'(8'hB0 + i));
        end
        st("vc0 after alt", 0, 0, 1'b0, 1'b1);

        // Full VC1 with simultaneous read+write: read wins, write rejected
        for (int i = 0; i < 16; i++) wr(1, 8'(8'h60 + i));
        st("vc1 full", 1, 16, 1'b1, 1'b0);
        drive(1'b1, 1, 8'h5A, 1'b1, 1, mk(1'b1, 8'h60, 1'b0, 1'b1, 1'b0));
        st("vc1 full rw", 1, 15, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) rd(1, 8'(8'h60 + i));
        st("vc1 half", 1, 8, 1'b0, 1'b0);
        drive(1'b1, 1, 8'h77, 1'b1, 1, mk(1'b1, 8'h68, 1'b0, 1'b0, 1'b0));
        st("vc1 half rw", 1, 8, 1'b0, 1'b0);
        for (int i = 9; i < 16; i++) rd(1, 8'(8'h60 + i));
        rd(1, 8'h77);
        st("vc1 final", 1, 0, 1'b0, 1'b1);

        // Same VC, empty: write lands, read rejected
        drive(1'b1, 2, 8'h3C, 1'b1, 2, mk(1'b0, 8'h77, 1'b1, 1'b0, 1'b1));
        st("vc2 empty rw", 2, 1, 1'b0, 1'b0);
        rd(2, 8'h3C);

        // Pointer wrap on VC0
        for (int i = 0; i < 40; i++) begin
            wr(0, 8'(i));
            st("wrap after wr", 0, 1, 1'b0, 1'b0);
            rd(0, 8'(i));
            st("wrap after rd", 0, 0, 1'b0, 1'b1);
        end

        // Asynchronous reset with a read outstanding
        for (int i = 0; i < 5; i++) wr(3, 8'(8'hC0 + i));
        rd(3, 8'hC0);
        chk("inflight valid", int'(bus.RD_VALID), 1);
        exp_q.delete();
        RSTn = 1'b0;
        #1;
        chk("async rst rd_valid", int'(bus.RD_VALID), 0);
        chk("async rst rd_data", int'(bus.RD_DATA), 0);
        st("vc3 after rst", 3, 0, 1'b0, 1'b1);
        chk("async rst empty", int'(bus.EMPTY), 'hF);
        @(negedge CLK);
        RSTn = 1'b1;
        wr(3, 8'h42);
        rd(3, 8'h42);

`ifdef VC_BUF_ALMOST_FULL_EN
        for (int i = 0; i < 14; i++) begin
            wr(0, 8'(i));
            chk("afull rise", int'(bus.AFULL[0]), (i == 13) ? 1 : 0);
        end
        rd(0, 8'h00);
        chk("afull fall", int'(bus.AFULL[0]), 0);
`endif

        repeat (4) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vc_buffer.md
Name: vc_buffer

Overview:
- Parametrised multi-virtual-channel synchronous FIFO buffer for a router input port.
- Holds NUM_VC independent FIFOs of DEPTH words each, in one shared storage array partitioned by VC.
- Each VC has its own read/write pointers, occupancy count and full/empty flags.
- Single clock. Registered read with 1-cycle latency. Replaces a bare dual-port RAM plus external pointer logic at each input port.

Parameters:
WIDTH, 8, data bits per flit
DEPTH, 16, words per VC; must be a power of two, >= 2
NUM_VC, 4, number of virtual channels, >= 1
VC_W, $clog2(NUM_VC) (min 1), VC select width
ADDR_W, $clog2(DEPTH), per-VC pointer width excluding wrap bit

Ports:
CLK  input  1  clock, all logic on rising edge
RSTn  input  1  asynchronous active-low reset
WR_EN  input  1  write request
WR_VC  input  VC_W  target VC of write
WR_DATA  input  WIDTH  write data
RD_EN  input  1  read request
RD_VC  input  VC_W  source VC of read
RD_DATA  output  WIDTH  read data, registered
RD_VALID  output  1  RD_DATA holds a word popped on the previous cycle
FULL  output  NUM_VC  per-VC full flag, combinational from pointers
EMPTY  output  NUM_VC  per-VC empty flag, combinational from pointers
COUNT  output  NUM_VC*(ADDR_W+1)  per-VC occupancy, VC v at bits [v*(ADDR_W+1) +: ADDR_W+1], range 0..DEPTH
WR_ERR  output  1  one-cycle pulse: write rejected
RD_ERR  output  1  one-cycle pulse: read rejected

Behaviour:
- Storage: NUM_VC*DEPTH words. Physical address = {VC, ptr[ADDR_W-1:0]}. Storage is not reset.
- Pointers: each VC has wptr and rptr of ADDR_W+1 bits, including a wrap bit.
  - EMPTY[v] = (wptr==rptr).
  - FULL[v] = (MSBs differ, LSBs equal).
  - COUNT[v] = wptr - rptr, modulo 2^(ADDR_W+1).
  - Pointers wrap naturally: DEPTH-1 -> 0 with the wrap bit toggling.
- Write: accepted when WR_EN and !FULL[WR_VC] at the clock edge. Data is stored and wptr[WR_VC] increments.
  - If FULL: nothing is stored and WR_ERR=1 on the next cycle.
- Read: accepted when RD_EN and !EMPTY[RD_VC]. On the next cycle RD_DATA = head word, RD_VALID=1, and rptr[RD_VC] increments.
  - If EMPTY: RD_DATA holds its previous value, RD_VALID=0, RD_ERR=1 next cycle.
  - When RD_EN=0: RD_VALID=0 next cycle and RD_DATA holds.
- Simultaneous write and read:
  - Different VCs: fully independent.
  - Same VC, not empty and not full: both succeed; COUNT unchanged.
  - Same VC and EMPTY: write succeeds, read rejected (no write-to-read bypass).
  - Same VC and FULL: read succeeds, write rejected. Flags are evaluated on pre-edge state.
- WR_VC or RD_VC >= NUM_VC (non-power-of-two NUM_VC): request rejected with the corresponding ERR pulse; no state change.
- Reset (RSTn low, any time, asynchronous):
  - All pointers 0; EMPTY all 1; FULL all 0; COUNT all 0.
  - RD_DATA=0, RD_VALID=0, WR_ERR=0, RD_ERR=0.
  - Any read in flight is discarded.
  - Release is synchronous to CLK by the integrating level; the first accepted request is on the first edge with RSTn high.

Optional Feature:
- Macro: VC_BUF_ALMOST_FULL_EN.
- When defined:
  - Adds parameter AFULL_THR (default DEPTH-2) and output AFULL [NUM_VC].
  - AFULL[v]=1 when COUNT[v] >= AFULL_THR, combinational. Used for credit back-pressure upstream.
  - Reset value of AFULL is all 0.
- When undefined: the port, the parameter and the compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset then write 0x11,0x22,0x33 to VC1 and read VC1 three times -> RD_DATA 0x11,0x22,0x33 on the cycle after each RD_EN with RD_VALID=1; COUNT[1] goes 3->0; EMPTY[1]=1 at the end.
- Write 16 words 0x00..0x0F to VC2, then a 17th write 0xFF -> FULL[2]=1 after the 16th; 17th gives WR_ERR pulse and COUNT[2] stays 16; 16 reads return 0x00..0x0F.
- Read VC0 while empty -> RD_ERR=1 and RD_VALID=0 next cycle; RD_DATA unchanged.
- Interleave writes to VC0 (0xA0..) and VC3 (0xB0..), then read alternately -> each VC returns its own order with no cross-VC corruption.
- Fill VC1, then same-cycle read+write 0x5A -> read returns the oldest word, write rejected; then same-cycle read+write on half-full VC1 -> COUNT unchanged.
- Wrap: 40 write/read pairs on VC0 with data = index -> data is always in order; pointers wrap twice with no false FULL/EMPTY.
- Reset mid-stream with VC3 holding 5 words and a read in flight -> RD_VALID drops immediately; COUNT[3]=0, EMPTY[3]=1.
- With VC_BUF_ALMOST_FULL_EN: 14 writes to VC0 -> AFULL[0] rises on the 14th; one read -> AFULL[0] falls.
